intc: RTL and testbench

Interrupt controller that sits directly upstream of the control unit and drives its `irq` input. It synchronises up to 32 asynchronous external interrupt lines, latches rising edges as pending, masks them with a software-writable enable register, and presents one aggregated, registered request to the control unit. The interrupt service routine accesses it as a memory-mapped peripheral at the interrupt vector. Software acknowledges a request by reading the CLAIM register.

---
 rtl/intc.sv | 90 +++++++++
 tb/tb_intc.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/intc.sv
// rtl/intc.sv - edge-latching interrupt controller with enable mask and claim register
module intc #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               sel,
  input  logic               rd,
  input  logic               wr,
  input  logic [1:0]         addr,
  input  logic [31:0]        din,
  output logic [31:0]        dout,
  output logic               irq
);

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_ENABLE  = 2'd1;
  localparam logic [1:0] ADDR_CLAIM   = 2'd2;

  logic [NUM_IRQ-1:0] s1, s2, h;
  logic [NUM_IRQ-1:0] pending, enable;
  logic [NUM_IRQ-1:0] edge_det, active, claim_mask, clr_mask, din_low;
  logic [31:0]        pend_ext, en_ext, claim_val, rdata;
  logic               rd_en, wr_en;
  logic               unused_din;

  assign rd_en      = sel & rd;
  assign wr_en      = sel & wr;
  assign din_low    = din[NUM_IRQ-1:0];
  assign unused_din = ^din;
  assign edge_det   = s2 & ~h;
  assign active     = pending & enable;

  // Lowest-numbered enabled pending line; scanning downward lets the lowest index overwrite last.
  always_comb begin
    claim_val  = 32'hFFFF_FFFF;
    claim_mask = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_val     = 32'(i);
        claim_mask    = '0;
        claim_mask[i] = 1'b1;
      end
    end
  end

  // Read mux; unused upper bits of PENDING and ENABLE read as zero.
  always_comb begin
    pend_ext = '0;
    en_ext   = '0;
    pend_ext[NUM_IRQ-1:0] = pending;
    en_ext[NUM_IRQ-1:0]   = enable;
    case (addr)
      ADDR_PENDING: rdata = pend_ext;
      ADDR_ENABLE:  rdata = en_ext;
      ADDR_CLAIM:   rdata = claim_val;
      default:      rdata = 32'h0;
    endcase
  end

  // Pending clears from a write-1-to-clear or a claim read; a same-cycle edge overrides them.
  always_comb begin
    clr_mask = '0;
    if (wr_en && addr == ADDR_PENDING) clr_mask = clr_mask | din_low;
    if (rd_en && addr == ADDR_CLAIM)   clr_mask = clr_mask | claim_mask;
  end

  // Synchroniser, edge history, pending, enable, registered irq and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= '0;
      s2      <= '0;
      h       <= '0;
      pending <= '0;
      enable  <= '0;
      irq     <= 1'b0;
      dout    <= 32'h0;
    end else begin
      s1      <= irq_in;
      s2      <= s1;
      h       <= s2;
      pending <= (pending & ~clr_mask) | edge_det;
      if (wr_en && addr == ADDR_ENABLE) enable <= din_low;
      irq     <= |active;
      if (rd_en) dout <= rdata;
    end
  end

endmodule

// File: tb/tb_intc.sv
// tb/tb_intc.sv - randomized and directed self-checking bench for intc
module tb_intc;

  localparam int N = 8;
  localparam logic [31:0] MASK = (N == 32) ? 32'hFFFF_FFFF : ((32'd1 << N) - 32'd1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic          sel = 1'b0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [31:0]   din = 32'h0;
  logic [31:0]   dout;
  logic          irq;

  intc #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .sel(sel), .rd(rd), .wr(wr),
    .addr(addr), .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: registers as plain vectors, input history as the last three samples.
  logic [31:0] m_pend, m_en, m_dout;
  logic        m_irq;
  logic [N-1:0] d1, d2, d3;

  task automatic model_reset();
    m_pend = 0; m_en = 0; m_dout = 0; m_irq = 0;
    d1 = '0; d2 = '0; d3 = '0;
  endtask

  task automatic model_edge();
    logic [31:0] set, act, clr, new_en;
    int ci;
    set = 32'(d2 & ~d3);
    act = m_pend & m_en;
    ci = -1;
    for (int i = 0; i < N; i++)
      if (act[i] && ci < 0) ci = i;
    if (sel && rd) begin
      case (addr)
        2'd0: m_dout = m_pend;
        2'd1: m_dout = m_en;
        2'd2: m_dout = (ci < 0) ? 32'hFFFF_FFFF : 32'(ci);
        default: m_dout = 0;
      endcase
    end
    clr = 0;
    if (sel && wr && addr == 2'd0) clr = din;
    if (sel && rd && addr == 2'd2 && ci >= 0) clr[ci] = 1'b1;
    new_en = m_en;
    if (sel && wr && addr == 2'd1) new_en = din & MASK;
    m_irq  = (act != 0);
    m_pend = ((m_pend & ~clr) | set) & MASK;
    m_en   = new_en;
    d3 = d2; d2 = d1; d1 = irq_in;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    check("irq", {31'b0, irq}, {31'b0, m_irq});
    check("dout", dout, m_dout);
  endtask

  task automatic access(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; rd = r; wr = w; addr = a; din = d;
    step();
    sel = 1'b0; rd = 1'b0; wr = 1'b0; din = 32'h0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
    access(1'b1, 1'b0, a, 32'h0);
    v = dout;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [31:0] v;

  initial begin
    model_reset();
    rst = 1'b0;
    idle(3);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_dout", dout, 32'h0);
    rst = 1'b1;
    idle(4);
    rd_reg(2'd0, v); check("rst_pending", v, 32'h0);
    rd_reg(2'd1, v); check("rst_enable", v, 32'h0);
    rd_reg(2'd3, v); check("rst_reserved", v, 32'h0);
    rd_reg(2'd2, v); check("rst_claim_none", v, 32'hFFFF_FFFF);
    check("rst_irq_low", {31'b0, irq}, 32'h0);

    // Single line: latency and claim
    access(1'b0, 1'b1, 2'd1, 32'h0000_000C);
    irq_in[2] = 1'b1;
    step(); step();
    irq_in[2] = 1'b0;
    step();
    check("irq_before_e4", {31'b0, irq}, 32'h0);
    step();
    check("irq_at_e4", {31'b0, irq}, 32'h1);
    rd_reg(2'd0, v); check("pending_line2", v, 32'h4);
    rd_reg(2'd2, v); check("claim_line2", v, 32'd2);
    step();
    check("irq_after_claim", {31'b0, irq}, 32'h0);
    rd_reg(2'd0, v); check("pending_cleared", v, 32'h0);

    // Two lines, priority order
    access(1'b0, 1'b1, 2'd1, 32'h0000_00FF);
    irq_in[5] = 1'b1; irq_in[3] = 1'b1;
    step(); step();
    irq_in[5] = 1'b0; irq_in[3] = 1'b0;
    idle(3);
    rd_reg(2'd2, v); check("claim_first", v, 32'd3);
    rd_reg(2'd2, v); check("claim_second", v, 32'd5);
    check("irq_held", {31'b0, irq}, 32'h1);
    rd_reg(2'd2, v); check("claim_empty", v, 32'hFFFF_FFFF);
    check("irq_dropped", {31'b0, irq}, 32'h0);

    // Masked line then enable / clear
    access(1'b0, 1'b1, 2'd1, 32'h0);
    irq_in[1] = 1'b1;
    step(); step();
    irq_in[1] = 1'b0;
    idle(3);
    rd_reg(2'd0, v); check("masked_pending", v, 32'h2);
    check("masked_irq", {31'b0, irq}, 32'h0);
    access(1'b0, 1'b1, 2'd1, 32'h2);
    step();
    check("enable_raises_irq", {31'b0, irq}, 32'h1);
    access(1'b0, 1'b1, 2'd0, 32'h2);
    step();
    check("w1c_drops_irq", {31'b0, irq}, 32'h0);

    // New edge coincides with claim of the same line
    access(1'b0, 1'b1, 2'd1, 32'h1);
    irq_in[0] = 1'b1;
    step(); step();
    irq_in[0] = 1'b0;
    idle(4);
    check("line0_irq", {31'b0, irq}, 32'h1);
    irq_in[0] = 1'b1;
    step(); step();
    rd_reg(2'd2, v); check("collide_claim", v, 32'd0);
    step();
    check("collide_irq", {31'b0, irq}, 32'h1);
    rd_reg(2'd0, v); check("collide_pending", v, 32'h1);
    irq_in[0] = 1'b0;

    // Asynchronous reset between edges
    access(1'b0, 1'b1, 2'd1, 32'hFF);
    rd_reg(2'd1, v);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    #3 rst = 1'b0;
    #1;
    check("async_irq", {31'b0, irq}, 32'h0);
    check("async_dout", dout, 32'h0);
    check("async_enable", 32'(dut.enable), 32'h0);
    check("async_pending", 32'(dut.pending), 32'h0);
    step();
    rst = 1'b1;
    idle(2);

    // Randomized traffic against the model
    for (int it = 0; it < 3000; it++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
      sel  = ($urandom_range(0, 2) != 0);
      rd   = $urandom_range(0, 1) == 1;
      wr   = $urandom_range(0, 3) == 0;
      addr = 2'($urandom_range(0, 3));
      din  = $urandom & $urandom;
      if (it % 500 == 499) rst = 1'b0;
      step();
      rst = 1'b1;
    end
    sel = 1'b0; rd = 1'b0; wr = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
